// File: rtl/table_read_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : table_read_engine_if
// Description : AXI4 read-channel bundle (AR + R) between the table read
//               engine and the memory interconnect.
//               master modport : engine side (drives AR, accepts R)
//               slave  modport : memory side (accepts AR, drives R)
// Revision    : 1.0 - initial release
// ============================================================================
interface table_read_engine_if;
    logic [31:0] m_axi_araddr;
    logic [3:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/table_read_engine.sv
`default_nettype none
// ============================================================================
// Module      : table_read_engine
// Description : Streams a table of 32-bit words from DDR over AXI4 read
//               bursts into a first-word-fall-through output FIFO.
//               Bursts never cross a 4 KB boundary and are only requested
//               when the FIFO can absorb the whole burst.
// Ports       : clk_i, reset_i (sync, active-high)
//               start_i/abort_i, addr_i/length_i : transfer control
//               busy_o, done_o, err_o            : transfer status
//               m_axi (master modport)           : AXI AR/R channels
//               dout_o/dout_valid_o/dout_ready_i : word stream to consumer
//               stats_o                          : accepted R-beat counter
// Options     : TABLE_READ_ENGINE_STATS_EN enables the stats_o counter;
//               without it stats_o is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module table_read_engine #(
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  wire logic           clk_i,
    input  wire logic           reset_i,
    input  wire logic           start_i,
    input  wire logic           abort_i,
    input  wire logic [31:0]    addr_i,
    input  wire logic [23:0]    length_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    table_read_engine_if.master m_axi,
    output logic [31:0]         dout_o,
    output logic                dout_valid_o,
    input  wire logic           dout_ready_i,
    output logic [31:0]         stats_o
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

    state_t             r_state;
    logic [31:0]        r_addr;
    logic [23:0]        r_remaining;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_arvalid;
    logic [31:0]        r_araddr;
    logic [3:0]         r_arlen;
    logic               r_rready;
    logic [3:0]         r_beat_cnt;
    logic               r_abort_pend;

    logic [31:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic [10:0]        w_to_bound;
    logic [4:0]         w_beats;
    logic [c_CNT_W-1:0] w_free;
    logic               w_space_ok;
    logic [4:0]         w_burst_beats;
    logic [23:0]        w_remaining_next;
    logic               w_rhs;
    logic               w_last;
    logic               w_beat_err;
    logic               w_aborting;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;

    // Words left before the next 4 KB page: 1..1024.
    assign w_to_bound = 11'd1024 - {1'b0, r_addr[11:2]};

    always_comb begin
        w_beats = 5'(BURST_LEN);
        if (r_remaining < 24'(w_beats)) w_beats = r_remaining[4:0];
        if (w_to_bound < 11'(w_beats))  w_beats = w_to_bound[4:0];
    end

    assign w_free           = c_CNT_W'(FIFO_DEPTH) - r_count;
    assign w_space_ok       = (32'(w_free) >= 32'(w_beats));
    assign w_burst_beats    = {1'b0, r_arlen} + 5'd1;
    assign w_remaining_next = r_remaining - {19'd0, w_burst_beats};

    assign w_rhs      = (r_state == S_DATA) && r_rready && m_axi.m_axi_rvalid;
    assign w_last     = (r_beat_cnt == r_arlen);
    assign w_beat_err = (m_axi.m_axi_rresp != 2'b00) || (m_axi.m_axi_rlast != w_last);
    // Once an abort is seen, beats of the in-flight burst are drained but dropped.
    assign w_aborting = r_abort_pend || abort_i;
    assign w_push     = w_rhs && !w_aborting;
    assign w_pop      = (r_count != '0) && dout_ready_i;
    assign w_flush    = ((r_state == S_ADDR) && !r_arvalid && abort_i) ||
                        (w_rhs && w_last && w_aborting);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_rready     <= 1'b0;
            r_beat_cnt   <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort_i wins over a coincident start_i.
                    if (start_i && !abort_i) begin
                        r_err        <= 1'b0;
                        r_addr       <= addr_i;
                        r_remaining  <= length_i;
                        r_abort_pend <= 1'b0;
                        if (length_i == 24'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (!r_arvalid) begin
                        if (abort_i) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (w_space_ok) begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= r_addr;
                            r_arlen   <= 4'(w_beats - 5'd1);
                        end
                    end else begin
                        // An issued request must complete its handshake.
                        if (abort_i) r_abort_pend <= 1'b1;
                        if (m_axi.m_axi_arready) begin
                            r_arvalid  <= 1'b0;
                            r_rready   <= 1'b1;
                            r_beat_cnt <= '0;
                            r_state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (abort_i) r_abort_pend <= 1'b1;
                    if (w_rhs) begin
                        if (w_beat_err) r_err <= 1'b1;
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                        if (w_last) begin
                            r_rready    <= 1'b0;
                            r_addr      <= r_addr + {25'd0, w_burst_beats, 2'b00};
                            r_remaining <= w_remaining_next;
                            if (w_aborting) begin
                                r_abort_pend <= 1'b0;
                                r_busy       <= 1'b0;
                                r_state      <= S_IDLE;
                            end else if ((w_remaining_next != 24'd0) && !r_err && !w_beat_err) begin
                                r_state <= S_ADDR;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output FIFO, first-word-fall-through.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= m_axi.m_axi_rdata;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef TABLE_READ_ENGINE_STATS_EN
    logic [31:0] r_stats;
    always_ff @(posedge clk_i) begin
        if (reset_i)    r_stats <= '0;
        else if (w_rhs) r_stats <= r_stats + 32'd1;
    end
    assign stats_o = r_stats;
`else
    assign stats_o = 32'd0;
`endif

    assign busy_o              = r_busy;
    assign done_o              = r_done;
    assign err_o               = r_err;
    assign dout_o              = r_mem[r_rptr];
    assign dout_valid_o        = (r_count != '0);
    assign m_axi.m_axi_araddr  = r_araddr;
    assign m_axi.m_axi_arlen   = r_arlen;
    assign m_axi.m_axi_arsize  = 3'b010;
    assign m_axi.m_axi_arburst = 2'b01;
    assign m_axi.m_axi_arvalid = r_arvalid;
    assign m_axi.m_axi_rready  = r_rready;
endmodule
`default_nettype wire

// File: doc/table_read_engine.md
TABLE_READ_ENGINE -- requirements
Module: table_read_engine

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, maximum beats per AXI read burst (power of two, 1..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, output FIFO depth in words (power of two, >= BURST_LEN).
REQ-003 SHALL have ports, one per line, name direction width meaning:
  clk_i  in  1  single clock for all logic
  reset_i  in  1  reset, synchronous and active-high
  start_i  in  1  one-cycle pulse: begin table transfer
  abort_i  in  1  one-cycle pulse: cancel transfer
  addr_i  in  32  DDR start byte address, word aligned
  length_i  in  24  transfer length in 32-bit words
  busy_o  out  1  transfer in progress
  done_o  out  1  one-cycle completion pulse
  err_o  out  1  sticky AXI error flag
  m_axi_araddr  out  32  read address
  m_axi_arlen  out  4  beats minus one
  m_axi_arsize  out  3  constant 3'b010
  m_axi_arburst  out  2  constant 2'b01 (INCR)
  m_axi_arvalid  out  1  address valid
  m_axi_arready  in  1  address ready
  m_axi_rdata  in  32  read data
  m_axi_rresp  in  2  read response
  m_axi_rlast  in  1  last beat
  m_axi_rvalid  in  1  data valid
  m_axi_rready  out  1  data ready
  dout_o  out  32  table word to consumer
  dout_valid_o  out  1  dout_o valid
  dout_ready_i  in  1  consumer accepts word
  stats_o  out  32  total words received (see Configuration)

Function
REQ-004 SHALL implement states IDLE, ADDR, DATA; start_i in IDLE latches addr_i/length_i, clears err_o, asserts busy_o next cycle, enters ADDR.
REQ-005 SHALL ignore start_i while busy_o=1.
REQ-006 SHALL, for length_i=0, pulse done_o the cycle after start_i without asserting m_axi_arvalid.
REQ-007 SHALL size each burst as beats = min(BURST_LEN, remaining words, words to next 4 KB boundary); m_axi_arlen = beats-1.
REQ-008 SHALL assert m_axi_arvalid in ADDR only when free FIFO space >= beats, holding araddr/arlen stable until arready; handshake -> DATA.
REQ-009 SHALL hold m_axi_rready=1 throughout DATA and push every accepted beat into the FIFO (no overflow possible by REQ-008).
REQ-010 SHALL end a burst on the internal beat count reaching arlen+1; m_axi_rlast disagreeing with that count SHALL set err_o.
REQ-011 SHALL, at burst end, advance address by beats*4 and decrement remaining; remaining>0 and err_o=0 -> ADDR, else -> IDLE with done_o pulse, busy_o low same cycle.
REQ-012 SHALL set err_o on any beat with m_axi_rresp != 2'b00, still accept and push the rest of that burst, and issue no further bursts.
REQ-013 SHALL implement the FIFO first-word-fall-through: dout_valid_o=1 whenever non-empty; pop on dout_valid_o & dout_ready_i; simultaneous push and pop leaves count unchanged.
REQ-014 SHALL, on abort_i: in IDLE ignore; in ADDR before arvalid go IDLE; with arvalid asserted complete the AR handshake; in DATA discard remaining beats of the current burst with rready=1; then IDLE, flush FIFO, no done_o.
REQ-015 SHALL give abort_i priority over start_i in the same cycle.

Reset
REQ-016 SHALL, on reset_i, enter IDLE, flush FIFO, clear busy_o, done_o, err_o, m_axi_arvalid, m_axi_rready, dout_valid_o, stats_o, araddr, arlen; reset mid-burst requires the interconnect reset in the same cycle.

Configuration
REQ-017 SHALL, with TABLE_READ_ENGINE_STATS_EN defined, count every accepted R beat in stats_o (wrap at 2^32, cleared only by reset_i); without it, stats_o SHALL be constant 0 with no counter logic.

Verification
REQ-018 addr 0x1000_0000, length 40, ready consumer -> arlen 15,15,7 at 0x1000_0000/0040/0080; 40 words in order; one done_o.
REQ-019 addr 0x1000_0FF0, length 16 -> arlen 3 at 0x1000_0FF0 then arlen 11 at 0x1000_1000; no 4 KB crossing.
REQ-020 length 64, dout_ready_i=0 -> exactly 2 bursts issued, third AR withheld until 16 words popped; no data lost.
REQ-021 length 40, rresp=2'b10 on beat 5 of burst 1 -> all 16 beats accepted, no second AR, done_o with err_o=1.
REQ-022 abort_i during burst 2 DATA -> remaining beats accepted and dropped, FIFO empty, busy_o low, no done_o; start_i while busy ignored; length 0 -> done_o next cycle.
